pzcorebus_response_slicer: RTL and testbench



---
 rtl/pzcorebus_response_slicer_if.sv | 44 ++++
 rtl/pzcorebus_response_slicer.sv | 105 ++++++++++
 tb/tb_pzcorebus_response_slicer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pzcorebus_response_slicer_if.sv
// Response-channel view of the pzcorebus interface used by the response slicer.
// Carries the valid/accept handshake plus the response payload, with pack and
// unpack helpers so that users can move the whole payload as one opaque vector.
interface pzcorebus_if #(
  parameter int unsigned BUS_CONFIG = '0
);
  localparam int DATA_WIDTH        = (BUS_CONFIG == 0) ? 8 : int'(BUS_CONFIG);
  localparam int ID_WIDTH          = 4;
  localparam int PACKED_RESPONSE_W = 1 + ID_WIDTH + DATA_WIDTH;

  logic                  sresp_valid;
  logic                  mresp_accept;
  logic                  serror;
  logic [ID_WIDTH-1:0]   sid;
  logic [DATA_WIDTH-1:0] sdata;

  function automatic logic [PACKED_RESPONSE_W-1:0] get_packed_response();
    return {serror, sid, sdata};
  endfunction

  function automatic void put_packed_response(
    logic [PACKED_RESPONSE_W-1:0] packed_response
  );
    {serror, sid, sdata} = packed_response;
  endfunction

  modport response_slave (
    input  sresp_valid,
    input  serror,
    input  sid,
    input  sdata,
    output mresp_accept,
    import get_packed_response
  );

  modport response_master (
    output sresp_valid,
    output serror,
    output sid,
    output sdata,
    input  mresp_accept,
    import put_packed_response
  );
endinterface

// File: rtl/pzcorebus_response_slicer.sv
// Register slice for the pzcorebus response channel. A chain of STAGES
// two-entry skid buffers cuts every combinational path (valid/data forward,
// accept backward) while sustaining one response per cycle. STAGES=0 is wires.
module pzcorebus_response_slicer #(
  parameter int unsigned BUS_CONFIG = '0,
  parameter int          STAGES     = 1,
  parameter bit          DATA_RESET = 1'b0
)(
  input logic                  i_clk,
  input logic                  i_rst_n,
  pzcorebus_if.response_slave  slave_if,
  pzcorebus_if.response_master master_if
);
  // Must agree with the packing done by pzcorebus_if for the same BUS_CONFIG.
  function automatic int get_packed_response_width(int unsigned bus_config);
    return 1 + 4 + ((bus_config == 0) ? 8 : int'(bus_config));
  endfunction

  localparam int W = get_packed_response_width(BUS_CONFIG);

  // Per-stage occupancy: bit 0 = main entry valid, bit 1 = skid entry valid.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] HALF  = 2'b01;
  localparam logic [1:0] FULL  = 2'b11;

  if (STAGES == 0) begin : g_bypass
    assign master_if.sresp_valid = slave_if.sresp_valid;
    assign slave_if.mresp_accept = master_if.mresp_accept;

    // Payload passes straight through.
    always_comb master_if.put_packed_response(slave_if.get_packed_response());
  end else begin : g_slice
    // Chain index k is the input of stage k; index STAGES is the block output.
    logic [STAGES:0] vld;
    logic [STAGES:0] acc;
    logic [W-1:0]    dat [0:STAGES];

    assign vld[0]                = slave_if.sresp_valid;
    assign dat[0]                = slave_if.get_packed_response();
    assign slave_if.mresp_accept = acc[0];
    assign master_if.sresp_valid = vld[STAGES];
    assign acc[STAGES]           = master_if.mresp_accept;

    // Unpack the last stage's main entry onto the downstream interface.
    always_comb master_if.put_packed_response(dat[STAGES]);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [1:0]   state;
      logic [W-1:0] main_data;
      logic [W-1:0] skid_data;
      logic         push;
      logic         pop;
      logic         main_load;
      logic         skid_load;

      // Accept comes straight from the skid flop, so no path crosses the stage.
      assign acc[k]     = !state[1];
      assign push       = vld[k] && acc[k];
      assign pop        = state[0] && acc[k+1];
      assign vld[k+1]   = state[0];
      assign dat[k+1]   = main_data;

      // Main loads on fill-from-empty, pass-through, or refill from skid.
      assign main_load  = (push && (!state[0] || pop)) || (state[1] && pop);
      // Skid catches the one response that arrives while main is stalled.
      assign skid_load  = push && state[0] && !pop;

      // Occupancy tracking; the async reset discards every entry.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          state <= EMPTY;
        end else begin
          case (state)
            EMPTY:   if (push) state <= HALF;
            HALF: begin
              if (push && !pop)      state <= FULL;
              else if (pop && !push) state <= EMPTY;
            end
            FULL:    if (pop) state <= HALF;
            default: state <= EMPTY;
          endcase
        end
      end

      if (DATA_RESET) begin : g_data_rst
        // Payload registers, cleared by reset so the output reads 0 while idle.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            main_data <= '0;
            skid_data <= '0;
          end else begin
            if (main_load) main_data <= state[1] ? skid_data : dat[k];
            if (skid_load) skid_data <= dat[k];
          end
        end
      end else begin : g_data_norst
        // Payload registers without reset; contents are don't-care while invalid.
        always_ff @(posedge i_clk) begin
          if (main_load) main_data <= state[1] ? skid_data : dat[k];
          if (skid_load) skid_data <= dat[k];
        end
      end
    end
  end
endmodule

// File: tb/tb_pzcorebus_response_slicer.sv
// Directed bench for pzcorebus_response_slicer. Four instances share clock and
// reset: STAGES=0 (wires), STAGES=1 with data reset, STAGES=2 and STAGES=3.
module tb_pzcorebus_response_slicer;
  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [3:0]  out_accept;
  logic [3:0]  out_valid;
  logic [3:0]  in_accept;
  logic [12:0] in_data  [4];
  logic [12:0] out_data [4];
  int          n_vec;
  int          n_err;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    pzcorebus_if sif ();
    pzcorebus_if mif ();

    assign sif.sresp_valid                = in_valid[g];
    assign {sif.serror, sif.sid, sif.sdata} = in_data[g];
    assign mif.mresp_accept               = out_accept[g];
    assign out_valid[g]                   = mif.sresp_valid;
    assign out_data[g]                    = {mif.serror, mif.sid, mif.sdata};
    assign in_accept[g]                   = sif.mresp_accept;

    pzcorebus_response_slicer #(
      .BUS_CONFIG (0),
      .STAGES     (g),
      .DATA_RESET (g == 1)
    ) u_dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .slave_if  (sif),
      .master_if (mif)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int          accepted;
    int          popped;
    logic        was_acc;
    logic        was_vld;
    logic [12:0] q [$];

    n_vec = 0;
    n_err = 0;

    // Reset held with upstream valid asserted.
    rst_n      = 1'b0;
    in_valid   = 4'hF;
    out_accept = 4'h0;
    for (int g = 0; g < 4; g++) in_data[g] = 13'h1A5;
    repeat (3) tick();
    for (int g = 1; g < 4; g++) begin
      check($sformatf("rst_out_valid_s%0d", g), out_valid[g], 0);
      check($sformatf("rst_in_accept_s%0d", g), in_accept[g], 1);
    end
    check("rst_data_zero_s1", out_data[1], 0);
    check("rst_bypass_valid_s0", out_valid[0], 1);
    in_valid = 4'h0;
    rst_n    = 1'b1;
    repeat (3) tick();
    for (int g = 1; g < 4; g++)
      check($sformatf("post_rst_empty_s%0d", g), out_valid[g], 0);

    // Latency through two stages, single response 0x5A.
    out_accept[2] = 1'b1;
    in_valid[2]   = 1'b1;
    in_data[2]    = 13'h05A;
    tick();
    in_valid[2] = 1'b0;
    check("lat_capture_valid", out_valid[2], 0);
    tick();
    check("lat_out_valid", out_valid[2], 1);
    check("lat_out_data", out_data[2], 32'h5A);
    tick();
    check("lat_one_cycle_only", out_valid[2], 0);

    // Back-to-back streaming through one stage.
    out_accept[1] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid[1] = 1'b1;
      in_data[1]  = 13'(i + 64);
      check("thr_in_accept", in_accept[1], 1);
      tick();
      check($sformatf("thr_valid_%0d", i), out_valid[1], 1);
      check($sformatf("thr_data_%0d", i), out_data[1], 32'(i + 64));
    end
    in_valid[1] = 1'b0;
    tick();
    check("thr_idle_after", out_valid[1], 0);

    // Stall three stages and fill them.
    out_accept[3] = 1'b0;
    accepted      = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid[3] = 1'b1;
      in_data[3]  = 13'(256 + accepted);
      was_acc     = in_accept[3];
      tick();
      if (was_acc) accepted++;
    end
    check("fill_count", accepted, 6);
    check("fill_accept_low", in_accept[3], 0);
    check("fill_head_valid", out_valid[3], 1);
    check("fill_head_data", out_data[3], 32'h100);

    // Release the stall and drain in order.
    in_valid[3]   = 1'b0;
    out_accept[3] = 1'b1;
    popped        = 0;
    for (int c = 0; c < 12; c++) begin
      was_vld = out_valid[3];
      if (was_vld) check($sformatf("drain_data_%0d", popped), out_data[3], 32'(256 + popped));
      tick();
      if (was_vld) popped++;
    end
    check("drain_count", popped, 6);
    check("drain_accept_back", in_accept[3], 1);
    check("drain_empty", out_valid[3], 0);

    // Random valid/accept on one stage against a queue.
    for (int c = 0; c < 10000; c++) begin
      was_acc       = in_accept[1];
      in_valid[1]   = 1'($urandom_range(0, 1));
      in_data[1]    = 13'($urandom);
      out_accept[1] = 1'($urandom_range(0, 1));
      #1;
      check("rand_accept_no_comb_path", in_accept[1], was_acc);
      if (in_valid[1] && in_accept[1]) q.push_back(in_data[1]);
      if (out_valid[1] && out_accept[1]) begin
        check("rand_queue_nonempty", (q.size() > 0), 1);
        if (q.size() > 0) check("rand_order", out_data[1], q.pop_front());
      end
      @(posedge clk);
      #1;
    end
    in_valid[1]   = 1'b0;
    out_accept[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (out_valid[1]) begin
        check("rand_drain_nonempty", (q.size() > 0), 1);
        if (q.size() > 0) check("rand_drain_order", out_data[1], q.pop_front());
      end
      tick();
    end
    check("rand_lossless", q.size(), 0);
    check("rand_drained", out_valid[1], 0);

    // Reset while two responses are buffered.
    out_accept[2] = 1'b0;
    in_valid[2]   = 1'b1;
    in_data[2]    = 13'h011;
    tick();
    in_data[2] = 13'h022;
    tick();
    in_valid[2] = 1'b0;
    repeat (2) tick();
    check("mid_buffered_valid", out_valid[2], 1);
    check("mid_buffered_head", out_data[2], 32'h11);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid_drop", out_valid[2], 0);
    check("mid_rst_accept", in_accept[2], 1);
    check("mid_rst_data_clear_s1", out_data[1], 0);
    repeat (2) tick();
    rst_n         = 1'b1;
    out_accept[2] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("mid_no_stale_%0d", c), out_valid[2], 0);
    end

    // Zero stages: combinational in both directions.
    in_valid[0]   = 1'b1;
    in_data[0]    = 13'h1234;
    out_accept[0] = 1'b1;
    #1;
    check("s0_valid_hi", out_valid[0], 1);
    check("s0_data_a", out_data[0], 32'h1234);
    check("s0_accept_hi", in_accept[0], 1);
    in_valid[0]   = 1'b0;
    in_data[0]    = 13'h0ABC;
    out_accept[0] = 1'b0;
    #1;
    check("s0_valid_lo", out_valid[0], 0);
    check("s0_data_b", out_data[0], 32'hABC);
    check("s0_accept_lo", in_accept[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
